shift_result_stage: RTL and testbench



---
 rtl/shift_result_stage.sv | 124 ++++++++++++
 tb/tb_shift_result_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_result_stage.sv
// shift_result_stage: 2-entry skid FIFO after the packed shift stage, capturing results, overflow bits and per-set flags.
// Optional statistics (sticky overflow per set, saturating overflow-beat count) are built when SHIFT_RESULT_STATS_EN is defined.
module shift_result_stage #(
    parameter int WIDTH = 4,
    parameter int SETS  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SETS*WIDTH-1:0]   shift_out_packed,
    input  logic [SETS*WIDTH-1:0]   shift_ovf_packed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SETS*WIDTH-1:0]   res_packed,
    output logic [SETS*WIDTH-1:0]   ovf_packed,
    output logic [SETS-1:0]         zero_flags,
    output logic [SETS-1:0]         ovf_flags,
    input  logic                    clr_stats,
    output logic [SETS-1:0]         sticky_ovf,
    output logic [15:0]             ovf_count
);
    localparam int W = SETS * WIDTH;
    localparam int E = 2 * W + 2 * SETS;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t         state_q, state_d;
    logic [E-1:0]   head_q, head_d, tail_q, tail_d;
    logic           rdy_en_q, rdy_en_d;
    logic [SETS-1:0] in_zero, in_oflag;
    logic [E-1:0]   in_entry;
    logic           push, pop;

    // Flags are derived at capture so the output path is pure storage
    always_comb begin
        in_zero  = '0;
        in_oflag = '0;
        for (int i = 0; i < SETS; i++) begin
            in_zero[i]  = shift_out_packed[i*WIDTH +: WIDTH] == '0;
            in_oflag[i] = shift_ovf_packed[i*WIDTH +: WIDTH] != '0;
        end
    end

    assign in_entry  = {shift_out_packed, shift_ovf_packed, in_zero, in_oflag};
    assign rdy_en_d  = 1'b1;
    assign in_ready  = rst_n && rdy_en_q && (state_q != TWO);
    assign out_valid = state_q != EMPTY;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign {res_packed, ovf_packed, zero_flags, ovf_flags} = head_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: if (push) begin
                state_d = ONE;
                head_d  = in_entry;
            end
            ONE: if (push && pop) begin
                head_d = in_entry;
            end else if (push) begin
                state_d = TWO;
                tail_d  = in_entry;
            end else if (pop) begin
                state_d = EMPTY;
            end
            TWO: if (pop) begin
                state_d = ONE;
                head_d  = tail_q;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            tail_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            rdy_en_q <= rdy_en_d;
        end
    end

`ifdef SHIFT_RESULT_STATS_EN
    logic [SETS-1:0] sticky_q, sticky_d;
    logic [15:0]     cnt_q, cnt_d;

    // Clear applies first so a coincident push survives it
    always_comb begin
        sticky_d = clr_stats ? '0 : sticky_q;
        cnt_d    = clr_stats ? '0 : cnt_q;
        if (push) begin
            sticky_d = sticky_d | in_oflag;
            cnt_d    = (|in_oflag && cnt_d != 16'hFFFF) ? cnt_d + 16'd1 : cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sticky_ovf = sticky_q;
    assign ovf_count  = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr_stats;
    assign sticky_ovf = '0;
    assign ovf_count  = '0;
`endif
endmodule

// File: tb/tb_shift_result_stage.sv
// tb_shift_result_stage: directed checks of shift_result_stage (WIDTH=4, SETS=2) against a queue model.
// Statistics expectations follow SHIFT_RESULT_STATS_EN (zero when undefined).
module tb_shift_result_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] shift_out_packed = '0;
    logic [7:0] shift_ovf_packed = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] res_packed;
    logic [7:0] ovf_packed;
    logic [1:0] zero_flags;
    logic [1:0] ovf_flags;
    logic       clr_stats = 1'b0;
    logic [1:0] sticky_ovf;
    logic [15:0] ovf_count;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    int base;
    logic [15:0] mq[$];
    logic        ready_en = 1'b0;
    logic [1:0]  m_sticky = '0;
    logic [15:0] m_cnt = '0;

    shift_result_stage #(.WIDTH(4), .SETS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .shift_out_packed(shift_out_packed), .shift_ovf_packed(shift_ovf_packed),
        .out_valid(out_valid), .out_ready(out_ready), .res_packed(res_packed),
        .ovf_packed(ovf_packed), .zero_flags(zero_flags), .ovf_flags(ovf_flags),
        .clr_stats(clr_stats), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] zf(input logic [7:0] r);
        return {r[7:4] == 4'd0, r[3:0] == 4'd0};
    endfunction

    function automatic logic [1:0] of(input logic [7:0] o);
        return {|o[7:4], |o[3:0]};
    endfunction

    // Check outputs against the model, then advance one edge and update the model
    task automatic cycle();
        logic push, pop;
        logic [1:0] fl;
        check("in_ready", 32'(in_ready), 32'(ready_en && mq.size() < 2));
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("res", 32'(res_packed), 32'(mq[0][15:8]));
            check("ovf", 32'(ovf_packed), 32'(mq[0][7:0]));
            check("zero_flags", 32'(zero_flags), 32'(zf(mq[0][15:8])));
            check("ovf_flags", 32'(ovf_flags), 32'(of(mq[0][7:0])));
        end
        check("sticky", 32'(sticky_ovf), 32'(m_sticky));
        check("count", 32'(ovf_count), 32'(m_cnt));
        push = in_valid && ready_en && mq.size() < 2;
        pop  = out_ready && mq.size() > 0;
        fl   = of(shift_ovf_packed);
`ifdef SHIFT_RESULT_STATS_EN
        if (clr_stats) begin
            m_sticky = '0;
            m_cnt    = '0;
        end
        if (push) begin
            m_sticky = m_sticky | fl;
            if (|fl && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
`endif
        @(posedge clk); #1;
        ready_en = 1'b1;
        if (pop) begin
            void'(mq.pop_front());
            n_pop++;
        end
        if (push) mq.push_back({shift_out_packed, shift_ovf_packed});
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] o);
        in_valid = v;
        shift_out_packed = r;
        shift_ovf_packed = o;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res", 32'(res_packed), 32'd0);
        check("rst_count", 32'(ovf_count), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("pre_edge_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        ready_en = 1'b1;

        // Single beat with hand-computed flags
        drive(1'b1, 8'h30, 8'h01);
        cycle();
        drive(1'b0, 8'h00, 8'h00);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_res", 32'(res_packed), 32'h30);
        check("t1_ovf", 32'(ovf_packed), 32'h01);
        check("t1_zero", 32'(zero_flags), 32'b01);
        check("t1_oflag", 32'(ovf_flags), 32'b01);
        out_ready = 1'b1;
        cycle();
        check("t1_drained", 32'(out_valid), 32'd0);

        // Backpressure: third beat held until a slot frees
        out_ready = 1'b0;
        base = n_pop;
        drive(1'b1, 8'h12, 8'h00); cycle();
        drive(1'b1, 8'h00, 8'h80); cycle();
        drive(1'b1, 8'h05, 8'h03);
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_head", 32'(res_packed), 32'h12);
        cycle(); cycle();
        out_ready = 1'b1;
        cycle(); cycle();
        drive(1'b0, 8'h00, 8'h00);
        cycle(); cycle();
        check("bp_pops", 32'(n_pop - base), 32'd3);

        // Streaming 20 beats at one per cycle
        base = n_pop;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i * 7 + 1), 8'(i % 3 == 0 ? 8'h20 : 8'h00));
            cycle();
        end
        drive(1'b0, 8'h00, 8'h00);
        cycle();
        check("stream_pops", 32'(n_pop - base), 32'd20);
        check("stream_empty", 32'(out_valid), 32'd0);

        // Statistics from a clean reset
        @(posedge clk); #2;
        rst_n = 1'b0;
        mq.delete();
        ready_en = 1'b0;
        m_sticky = '0;
        m_cnt = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ready_en = 1'b1;
        drive(1'b1, 8'h11, 8'h10); cycle();
        drive(1'b1, 8'h22, 8'h01); cycle();
        drive(1'b1, 8'h33, 8'h11); cycle();
        drive(1'b1, 8'h44, 8'h10);
`ifdef SHIFT_RESULT_STATS_EN
        check("stats_cnt3", 32'(ovf_count), 32'd3);
        check("stats_sticky3", 32'(sticky_ovf), 32'b11);
`else
        check("stats_off_cnt", 32'(ovf_count), 32'd0);
        check("stats_off_sticky", 32'(sticky_ovf), 32'd0);
`endif
        clr_stats = 1'b1;
        cycle();
        clr_stats = 1'b0;
`ifdef SHIFT_RESULT_STATS_EN
        check("stats_clr_cnt", 32'(ovf_count), 32'd1);
        check("stats_clr_sticky", 32'(sticky_ovf), 32'b10);
        // Saturation
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 8'(i), 8'h01);
            cycle();
        end
        check("sat_cnt", 32'(ovf_count), 32'hFFFF);
        cycle();
        check("sat_hold", 32'(ovf_count), 32'hFFFF);
`else
        check("stats_off_clr_cnt", 32'(ovf_count), 32'd0);
`endif

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        cycle(); cycle();
        drive(1'b1, 8'h5A, 8'h0F); cycle();
        drive(1'b1, 8'hA5, 8'hF0); cycle();
        drive(1'b0, 8'h00, 8'h00);
        check("ar_full", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd0);
        check("ar_res", 32'(res_packed), 32'd0);
        check("ar_ovf", 32'(ovf_packed), 32'd0);
        check("ar_flags", 32'({zero_flags, ovf_flags}), 32'd0);
        check("ar_stats", 32'({sticky_ovf, ovf_count}), 32'd0);
        mq.delete();
        ready_en = 1'b0;
        m_sticky = '0;
        m_cnt = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("ar_pre_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        ready_en = 1'b1;
        check("ar_post_edge", 32'(in_ready), 32'd1);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
